serial_adder: RTL and testbench

- Digit-serial, multi-cycle successor to the single-bit full_adder.
- Adds two WIDTH-bit operands plus a carry-in, CHUNK bits per clock, using one registered carry between chunks.
- Uses a start/done handshake so datapaths can trade area for latency, from one full-adder cell (CHUNK=1) up to a full ripple adder (CHUNK=WIDTH).
- Sits between operand registers and a result consumer in the arithmetic datapath.

---
 rtl/serial_adder_pkg.sv | 27 ++
 rtl/full_adder.sv | 13 +
 rtl/serial_adder_chunk_adder.sv | 34 +++
 rtl/serial_adder.sv | 132 +++++++++++++
 tb/tb_serial_adder.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding, a
// counter-width helper and the CHUNK/WIDTH elaboration check macro.
`ifndef SERIAL_ADDER_PKG_SV
`define SERIAL_ADDER_PKG_SV

package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A counter for n steps needs at least one bit even when n == 1.
    function automatic int count_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// Elaboration stops when CHUNK is not a positive divisor of WIDTH.
`define SERIAL_ADDER_CHUNK_CHECK(W, C) \
    if (((C) < 1) || (((W) % (C)) != 0)) begin : g_chunk_check \
        $error("serial_adder: CHUNK must be a positive divisor of WIDTH"); \
    end

`endif

// File: rtl/full_adder.sv
// Single-bit full adder cell; the building block of the chunk ripple.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_chunk_adder.sv
// CHUNK-bit combinational ripple adder built from full_adder cells; also
// exposes the carry into its top bit so the caller can form signed overflow.
module chunk_adder #(
    parameter int CHUNK = 1
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] carry;

    assign carry[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < CHUNK; gi++) begin : g_cell
            full_adder u_fa (
                .a    (a[gi]),
                .b    (b[gi]),
                .cin  (carry[gi]),
                .sum  (sum[gi]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    assign cout  = carry[CHUNK];
    assign c_msb = carry[CHUNK-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: CHUNK bits per clock with a start/done handshake.
// Optional subtract mode with signed overflow is enabled by SERIAL_ADDER_SUB_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_SUB_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = count_width(NCHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    `SERIAL_ADDER_CHUNK_CHECK(WIDTH, CHUNK)

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sr_reg, b_sr_reg, psum_reg, sum_reg;
    logic [CW-1:0]    count_reg;
    logic             carry_reg, cout_reg;

    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout, chunk_cmsb;
    logic [WIDTH-1:0] psum_next, b_load;
    logic             cin_load, accept, last_chunk;

`ifdef SERIAL_ADDER_SUB_EN
    logic ovf_reg;

    // Subtraction is a + ~b + ~cin, so cout=1 means no borrow.
    assign b_load   = sub ? ~b : b;
    assign cin_load = sub ? ~cin : cin;
    assign ovf      = ovf_reg;
`else
    logic unused_cmsb;

    assign b_load      = b;
    assign cin_load    = cin;
    assign unused_cmsb = chunk_cmsb;
`endif

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a     (a_sr_reg[CHUNK-1:0]),
        .b     (b_sr_reg[CHUNK-1:0]),
        .cin   (carry_reg),
        .sum   (chunk_sum),
        .cout  (chunk_cout),
        .c_msb (chunk_cmsb)
    );

    // New chunk bits enter at the top, so after NCHUNK steps the word is aligned.
    assign psum_next  = WIDTH'({chunk_sum, psum_reg} >> CHUNK);
    assign accept     = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign last_chunk = (count_reg == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_BUSY;
            ST_BUSY: if (last_chunk) state_next = ST_DONE;
            ST_DONE: state_next = start ? ST_BUSY : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr_reg  <= '0;
            b_sr_reg  <= '0;
            psum_reg  <= '0;
            sum_reg   <= '0;
            count_reg <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            ovf_reg   <= 1'b0;
`endif
        end else if (accept) begin
            a_sr_reg  <= a;
            b_sr_reg  <= b_load;
            carry_reg <= cin_load;
            count_reg <= '0;
            psum_reg  <= '0;
        end else if (state_reg == ST_BUSY) begin
            a_sr_reg  <= a_sr_reg >> CHUNK;
            b_sr_reg  <= b_sr_reg >> CHUNK;
            carry_reg <= chunk_cout;
            count_reg <= count_reg + CW'(1);
            psum_reg  <= psum_next;
            if (last_chunk) begin
                sum_reg  <= psum_next;
                cout_reg <= chunk_cout;
`ifdef SERIAL_ADDER_SUB_EN
                ovf_reg  <= chunk_cmsb ^ chunk_cout;
`endif
            end
        end
    end

    assign busy = (state_reg == ST_BUSY);
    assign done = (state_reg == ST_DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Randomised self-checking bench for serial_adder (CHUNK=1 and CHUNK=4 instances)
// against an arithmetic reference model.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, start4 = 1'b0;
    logic [7:0] a = '0, b = '0, a4 = '0, b4 = '0;
    logic       cin = 1'b0, cin4 = 1'b0;
    logic       busy, done, cout, busy4, done4, cout4;
    logic [7:0] sum, sum4;
    logic       sub = 1'b0, sub4 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    logic       ovf, ovf4;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .CHUNK(1)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_SUB_EN
        ,
        .ovf   (ovf)
`endif
    );

    serial_adder #(.WIDTH(8), .CHUNK(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub4),
`endif
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
`ifdef SERIAL_ADDER_SUB_EN
        ,
        .ovf   (ovf4)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: returns {ovf, cout, sum[7:0]} from plain integer arithmetic.
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic ci, input logic sb);
        int r, s, sx, sy;
        logic co, ov;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (!sb) begin
            r  = int'(x) + int'(y) + int'(ci);
            s  = sx + sy + int'(ci);
            co = (r > 255);
        end else begin
            r  = int'(x) - int'(y) - int'(ci);
            s  = sx - sy - int'(ci);
            co = (r >= 0);
        end
        ov = (s > 127) || (s < -128);
        return {ov, co, r[7:0]};
    endfunction

    task automatic run_op8(input logic [7:0] x, input logic [7:0] y, input logic ci,
                           input logic sb, input string tag);
        logic [9:0] exp;
        logic [7:0] prev_sum;
        int nb;
        bit got, held;
        exp = model(x, y, ci, sb);
        prev_sum = sum;
        a = x; b = y; cin = ci; sub = sb; start = 1'b1;
        tick;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        nb = 0; got = 0; held = 1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin got = 1; break; end
            if (busy) nb++;
            if (sum !== prev_sum) held = 0;
            tick;
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_busy_cycles"}, 32'(nb), 32'd8);
        check({tag, "_sum_held"}, 32'(held), 32'd1);
        check({tag, "_sum"}, 32'(sum), 32'(exp[7:0]));
        check({tag, "_cout"}, 32'(cout), 32'(exp[8]));
`ifdef SERIAL_ADDER_SUB_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(exp[9]));
`endif
        $display("op %s a=%02h b=%02h cin=%0d sub=%0d -> sum=%02h cout=%0d", tag, x, y, ci, sb, sum, cout);
        tick;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    task automatic run_op4(input logic [7:0] x, input logic [7:0] y, input logic ci,
                           input string tag);
        logic [9:0] exp;
        int nb;
        bit got;
        exp = model(x, y, ci, 1'b0);
        a4 = x; b4 = y; cin4 = ci; start4 = 1'b1;
        tick;
        start4 = 1'b0;
        nb = 0; got = 0;
        for (int i = 0; i < 20; i++) begin
            if (done4) begin got = 1; break; end
            if (busy4) nb++;
            tick;
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_busy_cycles"}, 32'(nb), 32'd2);
        check({tag, "_sum"}, 32'(sum4), 32'(exp[7:0]));
        check({tag, "_cout"}, 32'(cout4), 32'(exp[8]));
        $display("op %s a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d", tag, x, y, ci, sum4, cout4);
        tick;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] e1, e2;
        int n, ndone;
        bit got;

        // Reset and idle
        rst = 1'b1;
        repeat (3) tick;
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (done) ndone++;
        end
        check("idle_no_done", 32'(ndone), 32'd0);

        // Directed cases with hand-derived constants
        run_op8(8'h5A, 8'h3C, 1'b0, 1'b0, "basic");
        check("basic_const_sum", 32'(sum), 32'h96);
        run_op8(8'hFF, 8'h00, 1'b1, 1'b0, "wrap");
        check("wrap_const_sum", 32'(sum), 32'h00);
        check("wrap_const_cout", 32'(cout), 32'd1);
        run_op4(8'hF0, 8'h1F, 1'b1, "c4_wrap");
        check("c4_const_sum", 32'(sum4), 32'h10);
        check("c4_const_cout", 32'(cout4), 32'd1);

        // Back-to-back with start held high
        e1 = model(8'h12, 8'h34, 1'b1, 1'b0);
        e2 = model(8'hC8, 8'h77, 1'b0, 1'b0);
        a = 8'h12; b = 8'h34; cin = 1'b1; sub = 1'b0; start = 1'b1;
        tick;
        a = 8'hC8; b = 8'h77; cin = 1'b0;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin got = 1; break; end
            tick;
        end
        check("b2b_first_done", 32'(got), 32'd1);
        check("b2b_first_sum", 32'(sum), 32'(e1[7:0]));
        n = 0; got = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            n++;
            if (done) begin got = 1; break; end
        end
        start = 1'b0;
        check("b2b_second_done", 32'(got), 32'd1);
        check("b2b_spacing", 32'(n), 32'd9);
        check("b2b_second_sum", 32'(sum), 32'(e2[7:0]));
        check("b2b_second_cout", 32'(cout), 32'(e2[8]));
        $display("op b2b spacing=%0d sum=%02h cout=%0d", n, sum, cout);
        tick;

        // Start pulsed mid-BUSY must be ignored
        e1 = model(8'h21, 8'h43, 1'b0, 1'b0);
        a = 8'h21; b = 8'h43; cin = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (3) tick;
        a = 8'hEE; b = 8'hEE; cin = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin got = 1; break; end
            tick;
        end
        check("ign_done", 32'(got), 32'd1);
        check("ign_sum", 32'(sum), 32'(e1[7:0]));
        check("ign_cout", 32'(cout), 32'(e1[8]));
        tick;
        check("ign_no_restart", 32'(busy), 32'd0);
        $display("op ignored_start sum=%02h cout=%0d", sum, cout);

        // Reset in busy cycle 4
        a = 8'h33; b = 8'h44; cin = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (3) tick;
        check("midrst_was_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (done) ndone++;
        end
        check("midrst_no_done", 32'(ndone), 32'd0);
        $display("op mid_reset sum=%02h busy=%0d", sum, busy);
        run_op8(8'h01, 8'h01, 1'b0, 1'b0, "post_rst");
        check("post_rst_const", 32'(sum), 32'h02);

`ifdef SERIAL_ADDER_SUB_EN
        run_op8(8'h80, 8'h01, 1'b0, 1'b1, "sub_ovf");
        check("sub_const_sum", 32'(sum), 32'h7F);
        check("sub_const_cout", 32'(cout), 32'd1);
        check("sub_const_ovf", 32'(ovf), 32'd1);
        run_op8(8'h7F, 8'h01, 1'b0, 1'b0, "add_ovf");
        check("add_const_sum", 32'(sum), 32'h80);
        check("add_const_ovf", 32'(ovf), 32'd1);
`endif

        // Randomised operations on both instances
        for (int i = 0; i < 30; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
            run_op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), "rnd8");
`else
            run_op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, "rnd8");
`endif
        end
        for (int i = 0; i < 12; i++) begin
            run_op4(8'($urandom), 8'($urandom), 1'($urandom), "rnd4");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
